inst_fetch_unit: RTL
====================

# inst_fetch_unit

Instruction fetch stage between the program counter and decode. Each cycle it issues the current PC to instruction memory over a request/grant interface, tracks up to DEPTH outstanding requests, and buffers returned instructions with their addresses in a DEPTH-entry FIFO for decode. It drives the PC's stall input so that the PC advances exactly when a fetch is accepted, and on a taken branch it flushes buffered and in-flight wrong-path instructions.

## Interface
- ADDR_W, 32, instruction address width; word addressed, sequential PC step is +1.
- DATA_W, 32, instruction width.
- DEPTH, 2, maximum outstanding requests plus buffered instructions; power of 2, at least 2.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- pc_addr  in  ADDR_W  current PC output.
- branch_true  in  1  taken branch or redirect; the PC loads its new address at this edge.
- fetch_stall  out  1  drives the PC stall input; high means the PC holds.
- imem_req  out  1  fetch request.
- imem_addr  out  ADDR_W  request address; equals pc_addr.
- imem_gnt  in  1  memory accepts the request in this cycle.
- imem_rvalid  in  1  response data valid; in order, at least 1 cycle after its grant.
- imem_rdata  in  DATA_W  instruction word.
- id_valid  out  1  FIFO head holds a valid instruction.
- id_inst  out  DATA_W  head instruction.
- id_pc  out  ADDR_W  address of the head instruction.
- id_stall  in  1  decode backpressure; the head is not consumed.

## Operation
- State:
  - outstanding counter, 0..DEPTH.
  - discard counter, never greater than outstanding.
  - address queue, DEPTH entries, holds the issued addresses.
  - instruction FIFO, DEPTH entries of {addr, inst}, with a count.
- pop = id_valid & ~id_stall & ~branch_true.
- accept = imem_req & imem_gnt.
- credit = (outstanding + fifo_count − pop) < DEPTH.
- imem_req = rst & credit & ~branch_true. This is combinational from id_stall and branch_true.
- fetch_stall = ~rst | (~branch_true & ~accept).
  - The PC advances only on an accepted fetch.
  - fetch_stall is forced low during branch_true because the PC gives stall priority over branch; holding it high would lose the redirect.
- On accept: push imem_addr into the address queue; outstanding +1.
- On imem_rvalid:
  - Pop the address queue; outstanding −1.
  - If discard > 0: drop the data; discard −1.
  - Otherwise: write {popped addr, imem_rdata} to the FIFO tail.
- Simultaneous accept and rvalid: outstanding is unchanged; the queue pushes and pops together.
- On branch_true:
  - The FIFO is cleared at the edge; any pop in that cycle is ignored.
  - Any rvalid in that cycle is dropped.
  - discard ← outstanding − (imem_rvalid ? 1 : 0).
  - No request is issued, because pc_addr is the wrong path.
- A branch_true while discard > 0 recomputes discard by the same rule.
- Spurious imem_rvalid with outstanding = 0 is ignored; no state changes.
- The FIFO never overflows because credit bounds outstanding + fifo_count ≤ DEPTH.

## Timing
- Reset (rst low, asynchronous):
  - outstanding, discard, fifo_count and the pointers go to 0.
  - id_valid=0, id_inst=0, id_pc=0.
  - imem_req=0, fetch_stall=1.
- imem_addr always equals pc_addr combinationally.
- id_valid, id_inst and id_pc are registered state (head of the FIFO); there is no bypass from imem_rdata.
- Latency: grant at cycle N, rvalid at N+1, id_valid at N+2.
- Throughput is one instruction per cycle with 1-cycle memory latency and no id_stall, at DEPTH=2.
- Flush: with branch_true at cycle B, id_valid=0 at B+1. The first request for the new path is issued at B+1 when credit allows.
- Deasserting reset mid-operation (after an asynchronous clear) starts clean. The memory must also be reset, so no stale responses arrive.

## Test plan
- Reset release, gnt=1, 1-cycle rvalid, id_stall=0, pc 0,1,2… -> imem_req from the first cycle. id_valid from cycle 3 with id_pc 0,1,2 and matching id_inst. fetch_stall stays 0.
- imem_gnt held 0 for 3 cycles -> imem_req=1 and fetch_stall=1 throughout; pc_addr holds; the fetch completes after gnt rises.
- id_stall=1 for 5 cycles -> FIFO fills to 2, imem_req falls, fetch_stall=1, id_pc holds. On release, order is preserved with no loss or duplication.
- branch_true with 2 outstanding to addresses 5,6 and new PC 40 -> both responses dropped, id_valid=0 next cycle, next id_pc=40. fetch_stall=0 in the branch cycle.
- branch_true in the same cycle as rvalid, and a second branch during discard -> discard counts 1, then recomputed. No wrong-path instruction reaches decode.
- rst low mid-stream with 2 outstanding -> all outputs at reset values immediately. Restart from PC 0 is clean; a spurious rvalid is ignored.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: issues PC to imem, tracks in-flight requests, buffers {pc, inst} for decode.
// Latency: grant at N, rvalid at N+1, id_valid at N+2 (no bypass from imem_rdata).
// Backpressure: id_stall holds the FIFO head; requests stop when in-flight + buffered reaches DEPTH.
module inst_fetch_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              branch_true,
  output logic              fetch_stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              id_valid,
  output logic [DATA_W-1:0] id_inst,
  output logic [ADDR_W-1:0] id_pc,
  input  logic              id_stall
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [CW-1:0]     out_q, out_d;
  logic [CW-1:0]     disc_q, disc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     aq_wr_q, aq_rd_q;
  logic [PW-1:0]     ff_wr_q, ff_wr_d, ff_rd_q, ff_rd_d;
  logic [ADDR_W-1:0] aq_mem_q  [DEPTH];
  logic [ADDR_W-1:0] ff_addr_q [DEPTH];
  logic [DATA_W-1:0] ff_data_q [DEPTH];

  logic        pop, accept, rsp, drop, push, credit;
  logic [CW:0] occ;

  // Handshake decode: a response with nothing in flight is spurious and ignored entirely.
  always_comb begin
    pop         = id_valid & ~id_stall & ~branch_true;
    accept      = imem_req & imem_gnt;
    rsp         = imem_rvalid & (out_q != '0);
    drop        = rsp & (disc_q != '0);
    push        = rsp & ~drop & ~branch_true;
    occ         = {1'b0, out_q} + {1'b0, cnt_q} - {{CW{1'b0}}, pop};
    credit      = occ < DEPTH_C;
    imem_req    = rst & credit & ~branch_true;
    // Stall is released during a branch so the PC takes the redirect instead of holding.
    fetch_stall = ~rst | (~branch_true & ~accept);
    imem_addr   = pc_addr;
    id_valid    = cnt_q != '0;
    id_inst     = ff_data_q[ff_rd_q];
    id_pc       = ff_addr_q[ff_rd_q];
  end

  // Next-state for counters and FIFO pointers; a branch empties the FIFO and re-arms discard.
  always_comb begin
    out_d   = out_q;
    disc_d  = disc_q;
    cnt_d   = cnt_q;
    ff_wr_d = ff_wr_q;
    ff_rd_d = ff_rd_q;
    if (accept && !rsp) begin
      out_d = out_q + CW'(1);
    end else if (rsp && !accept) begin
      out_d = out_q - CW'(1);
    end
    if (branch_true) begin
      // Everything still in flight after this edge belongs to the wrong path.
      disc_d  = out_q - CW'(rsp);
      cnt_d   = '0;
      ff_wr_d = '0;
      ff_rd_d = '0;
    end else begin
      if (drop) begin
        disc_d = disc_q - CW'(1);
      end
      if (push) begin
        ff_wr_d = ff_wr_q + PW'(1);
      end
      if (pop) begin
        ff_rd_d = ff_rd_q + PW'(1);
      end
      if (push && !pop) begin
        cnt_d = cnt_q + CW'(1);
      end else if (pop && !push) begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  // State registers, address queue and instruction FIFO storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q   <= '0;
      disc_q  <= '0;
      cnt_q   <= '0;
      aq_wr_q <= '0;
      aq_rd_q <= '0;
      ff_wr_q <= '0;
      ff_rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        aq_mem_q[i]  <= '0;
        ff_addr_q[i] <= '0;
        ff_data_q[i] <= '0;
      end
    end else begin
      out_q   <= out_d;
      disc_q  <= disc_d;
      cnt_q   <= cnt_d;
      ff_wr_q <= ff_wr_d;
      ff_rd_q <= ff_rd_d;
      if (accept) begin
        aq_mem_q[aq_wr_q] <= imem_addr;
        aq_wr_q           <= aq_wr_q + PW'(1);
      end
      if (rsp) begin
        aq_rd_q <= aq_rd_q + PW'(1);
      end
      if (push) begin
        ff_addr_q[ff_wr_q] <= aq_mem_q[aq_rd_q];
        ff_data_q[ff_wr_q] <= imem_rdata;
      end
    end
  end

endmodule
